// File: rtl/noc_port_requester.sv
// Input-port requester: decodes the head flit, drives one-hot hi/lo requests to
// the output arbiters, forwards granted flits through a registered output stage.
module noc_port_requester #(
  parameter int FLIT_W       = 32,
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              flit_ready,
  output logic [7:0]        req_hi,
  output logic [7:0]        req_lo,
  input  logic [7:0]        gnt,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_data,
  output logic [7:0]        out_sel,
  input  logic              out_ready,
  output logic              proto_err,
  output logic [CNT_W-1:0]  pkt_count
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          dest_q, dest_d;
  logic                urg_q, urg_d;
  logic                promote_q, promote_d;
  logic                first_q, first_d;
  logic [SC_W-1:0]     starve_cnt_q, starve_cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic [7:0]          out_sel_q, out_sel_d;
  logic                proto_err_q, proto_err_d;
  logic [CNT_W-1:0]    pkt_count_q, pkt_count_d;

  logic                is_head;
  logic                is_tail;
  logic [7:0]          dest_onehot;
  logic [7:0]          req;
  logic                can_load;
  logic                fire;

  // Type field: bit FLIT_W-2 marks a head, bit FLIT_W-1 marks a tail (single = both).
  assign is_head     = flit_data[FLIT_W-2];
  assign is_tail     = flit_data[FLIT_W-1];
  assign dest_onehot = 8'b1 << dest_q;
  assign can_load    = !out_valid_q || out_ready;

  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    urg_d        = urg_q;
    promote_d    = promote_q;
    first_d      = first_q;
    starve_cnt_d = starve_cnt_q;
    proto_err_d  = 1'b0;
    pkt_count_d  = pkt_count_q;
    flit_ready   = 1'b0;
    req          = '0;
    req_hi       = '0;
    req_lo       = '0;
    fire         = 1'b0;

    unique case (state_q)
      IDLE: begin
        starve_cnt_d = '0;
        if (flit_valid) begin
          if (is_head) begin
            dest_d  = flit_data[2:0];
            urg_d   = flit_data[3];
            first_d = 1'b1;
            state_d = ACTIVE;
          end else begin
            flit_ready  = 1'b1;
            proto_err_d = 1'b1;
          end
        end
      end

      ACTIVE: begin
        req = flit_valid ? dest_onehot : '0;
        if (urg_q || promote_q) begin
          req_hi = req;
        end else begin
          req_lo = req;
        end
        fire       = flit_valid && gnt[dest_q] && can_load;
        flit_ready = fire;

        if (fire) begin
          starve_cnt_d = '0;
          first_d      = 1'b0;
          // The packet's own head fires with first_q set; any later head is stray.
          if (is_head && !first_q) begin
            proto_err_d = 1'b1;
          end
          if (is_tail) begin
            state_d     = IDLE;
            pkt_count_d = pkt_count_q + CNT_W'(1);
            promote_d   = 1'b0;
          end
        end else if (flit_valid) begin
          if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
            if (starve_cnt_q == SC_W'(STARVE_LIMIT - 1)) begin
              promote_d = 1'b1;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (fire) begin
      out_valid_d = 1'b1;
      out_data_d  = flit_data;
      out_sel_d   = dest_onehot;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dest_q       <= '0;
      urg_q        <= 1'b0;
      promote_q    <= 1'b0;
      first_q      <= 1'b0;
      starve_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      proto_err_q  <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      urg_q        <= urg_d;
      promote_q    <= promote_d;
      first_q      <= first_d;
      starve_cnt_q <= starve_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      proto_err_q  <= proto_err_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign proto_err = proto_err_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: doc/noc_port_requester.md
Name: noc_port_requester

Overview:
- Input-port side of the router crossbar. It decodes the head flit of each packet at its input buffer, drives one-hot high/low priority requests to the 8 output-port arbiters, and consumes their per-cycle grants.
- It forwards flits through a registered output stage and releases its request after the tail flit.
- Starving low-priority requests are promoted to high priority.
- One instance per router input port.

Parameters:
- FLIT_W, 32, flit width. Bits [FLIT_W-1:FLIT_W-2] are the type: 01 head, 00 body, 10 tail, 11 single (head+tail). In head/single flits, bits [2:0] are the destination port and bit [3] is urgent.
- STARVE_LIMIT, 16, consecutive ungranted requesting cycles before low→high promotion (≥2).
- CNT_W, 16, width of the packet counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flit_valid  in  1  input buffer has a flit.
- flit_data  in  FLIT_W  input buffer head flit.
- flit_ready  out  1  pop strobe to the input buffer; combinational.
- req_hi  out  8  one-hot high-priority request to output arbiters; combinational from registers and flit_valid.
- req_lo  out  8  one-hot low-priority request.
- gnt  in  8  per-output arbitration result for this port; only bit dest_q is honoured.
- out_valid  out  1  registered flit valid toward the crossbar.
- out_data  out  FLIT_W  registered flit.
- out_sel  out  8  registered one-hot crossbar column select.
- out_ready  in  1  crossbar/downstream accepts out_data.
- proto_err  out  1  one-cycle pulse, registered.
- pkt_count  out  CNT_W  packets fully forwarded, wraps.

Behaviour:
- State register has two states, IDLE and ACTIVE. Internal registers: dest_q[2:0], urg_q, promote_q, starve_cnt.
- Reset (async, rst=1) sets:
  - state IDLE
  - out_valid, out_data, out_sel to 0
  - proto_err 0, pkt_count 0, starve_cnt 0
  - dest_q, urg_q, promote_q to 0
- Reset mid-packet discards all progress. Upstream remainder is not flushed.
- IDLE state:
  - req_hi and req_lo are 0.
  - Head or single flit with flit_valid=1: latch dest_q and urg_q, go to ACTIVE. The flit is NOT popped (flit_ready=0).
  - Body or tail flit with flit_valid=1: pop it (flit_ready=1), drop it, pulse proto_err next cycle, stay IDLE.
- ACTIVE state requests:
  - req = flit_valid ? (1<<dest_q) : 0.
  - req_hi = req when (urg_q|promote_q); otherwise req_lo = req.
  - The other request vector is 0.
- ACTIVE state fire:
  - can_load = !out_valid | out_ready.
  - fire = flit_valid & gnt[dest_q] & can_load.
  - flit_ready = fire. gnt bits other than dest_q are ignored.
- Output stage:
  - On fire: out_valid←1, out_data←flit_data, out_sel←(1<<dest_q).
  - Else if out_ready: out_valid←0. out_data and out_sel hold.
  - A held out_valid=1 is stable until out_ready.
- Tail or single fire: next state IDLE, pkt_count+1 (wraps at 2^CNT_W), promote_q←0.
- A head/single flit seen while ACTIVE (before its tail fires) is a protocol error:
  - it is forwarded normally;
  - proto_err pulses.
- Starvation:
  - In ACTIVE, starve_cnt+1 each cycle with req≠0 and !fire, saturating at STARVE_LIMIT.
  - starve_cnt clears on fire and in IDLE.
  - When the increment reaches STARVE_LIMIT, promote_q←1. It is sticky until tail fire or reset.
  - Promotion does not apply to already-urgent packets. It is harmless there.
- Latency:
  - Head appears at cycle T, IDLE → requests from T+1.
  - Grant at T+1 → fire at T+1, out_valid at T+2.
  - Back-to-back packets: tail fires at T, the next head is decoded at T+1, and its earliest fire is T+2 (one bubble).
- Grant arriving while can_load=0: no fire, the flit stays, and the cycle counts toward starvation.
- flit_valid=0 in ACTIVE: requests drop to 0 and starvation does not count. The state is kept.

Test Plan:
- Single flit {11, urgent=1, dest=5}, gnt=8'h20 held, out_ready=1:
  - req_hi=8'h20 at T+1, fire at T+1;
  - out_valid=1, out_sel=8'h20 at T+2;
  - pkt_count=1, back to IDLE.
- 4-flit packet to dest=2, low priority, gnt[2] toggling 1,0,1,0,…:
  - req_lo=8'h04 throughout;
  - flits are forwarded only on granted cycles, in order;
  - req drops the cycle after tail fire.
- Low-priority dest=7, gnt=0 for 16 cycles, STARVE_LIMIT=16:
  - req_lo=8'h80 for 16 cycles, then req_hi=8'h80 and req_lo=0;
  - after grant and tail, the next packet starts on req_lo again.
- out_ready=0 with out_valid=1 and gnt[dest]=1:
  - no fire, flit_ready=0, out_data stable;
  - raising out_ready fires the same cycle with a seamless handoff.
- Body flit at IDLE:
  - popped, proto_err=1 for exactly one cycle, no requests.
  - A stray head inside a packet gives a proto_err pulse and the flit is forwarded.
- Assert rst mid-packet (state ACTIVE, out_valid=1):
  - outputs 0 asynchronously, req 0, pkt_count 0;
  - after release, a new head is decoded normally.
